wb_cmd_master: RTL and testbench
================================

WB_CMD_MASTER -- requirements
Module: wb_cmd_master

Interface
REQ-001 SHALL have parameter ADR_W, default 6, meaning the Wishbone byte-address width (matches the syscon slave address port).
REQ-002 SHALL have parameter TIMEOUT, default 255, meaning the maximum cycles to wait for ack, range 1..65535.
REQ-003 i_clk  in  1  the single clock; all logic is on its rising edge.
REQ-004 i_rst_n  in  1  reset, asynchronous, active-low.
REQ-005 i_cmd_valid  in  1  a command is offered.
REQ-006 o_cmd_ready  out  1  a command is accepted when valid and ready are both high at a clock edge.
REQ-007 i_cmd_adr  in  ADR_W  target byte address.
REQ-008 i_cmd_dat  in  32  write data.
REQ-009 i_cmd_sel  in  4  byte enables.
REQ-010 i_cmd_we  in  1  1 = write, 0 = read.
REQ-011 o_rsp_valid  out  1  a response is pending.
REQ-012 i_rsp_ready  in  1  the consumer takes the response.
REQ-013 o_rsp_rdt  out  32  read data; 0 for writes and timeouts.
REQ-014 o_rsp_err  out  1  the transaction timed out.
REQ-015 o_wb_adr, o_wb_dat, o_wb_sel, o_wb_we  out  ADR_W/32/4/1  Wishbone classic request fields.
REQ-016 o_wb_cyc, o_wb_stb  out  1  Wishbone cycle and strobe, always driven identically.
REQ-017 i_wb_rdt  in  32  slave read data; i_wb_ack  in  1  slave acknowledge.

Function
REQ-018 SHALL implement a three-state FSM: IDLE, BUS, RESP.
REQ-019 o_cmd_ready SHALL be high only in IDLE.
REQ-020 IDLE->BUS SHALL occur on valid&ready; the adr, dat, sel and we fields are registered at that edge onto o_wb_*.
REQ-021 o_wb_cyc and o_wb_stb SHALL be asserted the cycle after acceptance and held, with all request fields stable, until ack or timeout.
REQ-022 In BUS, i_wb_ack=1 at an edge SHALL:
  - deassert cyc/stb at that edge;
  - capture i_wb_rdt into o_rsp_rdt for reads, or 0 for writes;
  - set o_rsp_err=0;
  - go to RESP.
REQ-023 A 16-bit wait counter SHALL clear on BUS entry and increment each BUS cycle without ack.
REQ-024 When the counter reaches TIMEOUT-1 without ack, the FSM SHALL:
  - drop cyc/stb;
  - set o_rsp_rdt=0 and o_rsp_err=1;
  - go to RESP.
REQ-025 If ack and timeout coincide, ack SHALL win (err=0).
REQ-026 o_rsp_valid SHALL be high exactly in RESP; o_rsp_rdt and o_rsp_err SHALL be stable while valid.
REQ-027 RESP->IDLE SHALL occur on i_rsp_ready=1; the next command can be accepted no earlier than the following cycle.
REQ-028 Against a slave that acks one cycle after cyc (syscon behaviour), acceptance-to-rsp_valid latency SHALL be 3 cycles.
REQ-029 i_wb_ack outside BUS SHALL be ignored.
REQ-030 At most one transaction SHALL be outstanding at any time; the block has no pipelining or bursts.

Reset
REQ-031 Asserting i_rst_n low SHALL immediately (asynchronously) set:
  - state=IDLE;
  - o_wb_cyc=o_wb_stb=0 and o_wb_we=0;
  - o_wb_adr, o_wb_dat, o_wb_sel=0;
  - o_rsp_valid=0, o_rsp_err=0, o_rsp_rdt=0;
  - wait counter=0.
REQ-032 o_cmd_ready SHALL read 1 during and after reset.
REQ-033 Reset asserted mid-BUS SHALL abort the cycle without producing a response.

Structure
REQ-034 The state enum (IDLE/BUS/RESP) and the default TIMEOUT constant SHALL live in shared package swervolf_wbm_pkg.
REQ-035 The wait counter SHALL be one sub-module, wbm_timeout_ctr, with inputs clear/enable and a terminal-count output.

Verification
REQ-036 Write test: cmd adr=0x38, dat=0x00001234, sel=4'hF, we=1, syscon-style 1-cycle ack -> one cyc pulse of 2 cycles; rsp_valid 3 cycles after accept; rdt=0; err=0.
REQ-037 Read test: cmd adr=0x3C, we=0, slave returns 0x05F5E100 with ack -> o_rsp_rdt=0x05F5E100, err=0.
REQ-038 Timeout test: TIMEOUT=8, slave never acks -> cyc high exactly 8 cycles, then rsp_valid with err=1, rdt=0.
REQ-039 Backpressure test: hold rsp_ready=0 for 10 cycles -> rsp fields stable, cmd_ready=0 throughout, cyc=0; release -> IDLE next cycle.
REQ-040 Reset test: assert i_rst_n low while cyc=1 -> cyc/stb drop without a clock edge; no rsp_valid after reset release.
REQ-041 Coincidence test: ack on the terminal timeout cycle -> err=0, data captured.

Source files
------------

// File: rtl/swervolf_wbm_pkg.sv
// Shared state encoding, counter width and default timeout for the Wishbone command master.
package swervolf_wbm_pkg;

    localparam int unsigned WBM_CNT_W       = 16;
    localparam int unsigned TIMEOUT_DEFAULT = 255;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUS  = 2'd1,
        ST_RESP = 2'd2
    } wbm_state_e;

    typedef struct packed {
        logic [31:0] rdt;
        logic        err;
    } wbm_rsp_t;

    // The counter flags its terminal value on the last wait cycle that is still allowed.
    function automatic logic [WBM_CNT_W-1:0] wbm_tc_value(input int unsigned timeout);
        wbm_tc_value = WBM_CNT_W'(timeout - 1);
    endfunction

endpackage

// File: rtl/wb_cmd_master_if.sv
// Command, response and Wishbone classic signal bundle for wb_cmd_master.
interface wb_cmd_master_if #(
    parameter int unsigned ADR_W = 6
);
    logic             i_cmd_valid;
    logic             o_cmd_ready;
    logic [ADR_W-1:0] i_cmd_adr;
    logic [31:0]      i_cmd_dat;
    logic [3:0]       i_cmd_sel;
    logic             i_cmd_we;

    logic             o_rsp_valid;
    logic             i_rsp_ready;
    logic [31:0]      o_rsp_rdt;
    logic             o_rsp_err;

    logic [ADR_W-1:0] o_wb_adr;
    logic [31:0]      o_wb_dat;
    logic [3:0]       o_wb_sel;
    logic             o_wb_we;
    logic             o_wb_cyc;
    logic             o_wb_stb;
    logic [31:0]      i_wb_rdt;
    logic             i_wb_ack;

    modport master (
        input  i_cmd_valid, i_cmd_adr, i_cmd_dat, i_cmd_sel, i_cmd_we,
        input  i_rsp_ready, i_wb_rdt, i_wb_ack,
        output o_cmd_ready, o_rsp_valid, o_rsp_rdt, o_rsp_err,
        output o_wb_adr, o_wb_dat, o_wb_sel, o_wb_we, o_wb_cyc, o_wb_stb
    );

    modport slave (
        output i_cmd_valid, i_cmd_adr, i_cmd_dat, i_cmd_sel, i_cmd_we,
        output i_rsp_ready, i_wb_rdt, i_wb_ack,
        input  o_cmd_ready, o_rsp_valid, o_rsp_rdt, o_rsp_err,
        input  o_wb_adr, o_wb_dat, o_wb_sel, o_wb_we, o_wb_cyc, o_wb_stb
    );

endinterface

// File: rtl/wbm_timeout_ctr.sv
// Wait-cycle counter for the bus phase; o_tc marks the last cycle allowed before timeout.
module wbm_timeout_ctr
    import swervolf_wbm_pkg::*;
#(
    parameter logic [WBM_CNT_W-1:0] TC_VALUE = wbm_tc_value(TIMEOUT_DEFAULT)
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_clear,
    input  logic i_enable,
    output logic o_tc
);

    logic [WBM_CNT_W-1:0] cnt_q;
    logic [WBM_CNT_W-1:0] cnt_d;

    assign o_tc = (cnt_q == TC_VALUE);

    // Hold at the terminal value so the count can never wrap back into range.
    always_comb begin
        cnt_d = cnt_q;
        if (i_clear) begin
            cnt_d = '0;
        end else if (i_enable && !o_tc) begin
            cnt_d = cnt_q + WBM_CNT_W'(1);
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/wb_cmd_master.sv
// Single-outstanding Wishbone classic master: accepts one command, runs one bus cycle
// with an ack timeout, and holds the response until the consumer takes it.
module wb_cmd_master
    import swervolf_wbm_pkg::*;
#(
    parameter int unsigned ADR_W   = 6,
    parameter int unsigned TIMEOUT = TIMEOUT_DEFAULT
) (
    input  logic            i_clk,
    input  logic            i_rst_n,
    wb_cmd_master_if.master bus
);

    wbm_state_e       state_q;
    wbm_state_e       state_d;
    logic [ADR_W-1:0] wb_adr_q;
    logic [ADR_W-1:0] wb_adr_d;
    logic [31:0]      wb_dat_q;
    logic [31:0]      wb_dat_d;
    logic [3:0]       wb_sel_q;
    logic [3:0]       wb_sel_d;
    logic             wb_we_q;
    logic             wb_we_d;
    logic             wb_cyc_q;
    logic             wb_cyc_d;
    wbm_rsp_t         rsp_q;
    wbm_rsp_t         rsp_d;

    logic             accept;
    logic             ctr_clear;
    logic             ctr_enable;
    logic             ctr_tc;

    assign accept     = (state_q == ST_IDLE) && bus.i_cmd_valid;
    assign ctr_clear  = (state_q != ST_BUS);
    assign ctr_enable = (state_q == ST_BUS) && !bus.i_wb_ack;

    wbm_timeout_ctr #(
        .TC_VALUE (wbm_tc_value(TIMEOUT))
    ) u_timeout_ctr (
        .i_clk    (i_clk),
        .i_rst_n  (i_rst_n),
        .i_clear  (ctr_clear),
        .i_enable (ctr_enable),
        .o_tc     (ctr_tc)
    );

    always_comb begin
        state_d  = state_q;
        wb_adr_d = wb_adr_q;
        wb_dat_d = wb_dat_q;
        wb_sel_d = wb_sel_q;
        wb_we_d  = wb_we_q;
        wb_cyc_d = wb_cyc_q;
        rsp_d    = rsp_q;

        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    state_d  = ST_BUS;
                    wb_adr_d = bus.i_cmd_adr;
                    wb_dat_d = bus.i_cmd_dat;
                    wb_sel_d = bus.i_cmd_sel;
                    wb_we_d  = bus.i_cmd_we;
                    wb_cyc_d = 1'b1;
                end
            end
            ST_BUS: begin
                // Ack is tested first so an ack on the terminal wait cycle still completes cleanly.
                if (bus.i_wb_ack) begin
                    state_d   = ST_RESP;
                    wb_cyc_d  = 1'b0;
                    rsp_d.rdt = wb_we_q ? 32'h0 : bus.i_wb_rdt;
                    rsp_d.err = 1'b0;
                end else if (ctr_tc) begin
                    state_d   = ST_RESP;
                    wb_cyc_d  = 1'b0;
                    rsp_d.rdt = 32'h0;
                    rsp_d.err = 1'b1;
                end
            end
            ST_RESP: begin
                if (bus.i_rsp_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d  = ST_IDLE;
                wb_cyc_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q  <= ST_IDLE;
            wb_adr_q <= '0;
            wb_dat_q <= '0;
            wb_sel_q <= '0;
            wb_we_q  <= 1'b0;
            wb_cyc_q <= 1'b0;
            rsp_q    <= '0;
        end else begin
            state_q  <= state_d;
            wb_adr_q <= wb_adr_d;
            wb_dat_q <= wb_dat_d;
            wb_sel_q <= wb_sel_d;
            wb_we_q  <= wb_we_d;
            wb_cyc_q <= wb_cyc_d;
            rsp_q    <= rsp_d;
        end
    end

    assign bus.o_cmd_ready = (state_q == ST_IDLE);
    assign bus.o_rsp_valid = (state_q == ST_RESP);
    assign bus.o_rsp_rdt   = rsp_q.rdt;
    assign bus.o_rsp_err   = rsp_q.err;
    assign bus.o_wb_adr    = wb_adr_q;
    assign bus.o_wb_dat    = wb_dat_q;
    assign bus.o_wb_sel    = wb_sel_q;
    assign bus.o_wb_we     = wb_we_q;
    assign bus.o_wb_cyc    = wb_cyc_q;
    assign bus.o_wb_stb    = wb_cyc_q;

endmodule

// File: tb/tb_wb_cmd_master.sv
// Directed and randomised bench for wb_cmd_master; expected outputs come from a
// transaction-timing model driven only by the stimulus the bench itself applies.
module tb_wb_cmd_master;

    localparam int unsigned ADR_W = 6;
    localparam int          TMO   = 8;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;

    wb_cmd_master_if #(.ADR_W(ADR_W)) bus ();

    wb_cmd_master #(
        .ADR_W   (ADR_W),
        .TIMEOUT (TMO)
    ) dut (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .bus     (bus)
    );

    initial begin
        forever #5 clk = ~clk;
    end

    int checks   = 0;
    int failures = 0;
    int cyc_n    = 0;

    int          plan_ack    = 0;
    bit          rdt_fix_en  = 1'b0;
    logic [31:0] rdt_fix     = 32'h0;
    bit          spurious_en = 1'b1;
    bit          chk_en      = 1'b0;

    bit               m_busy  = 1'b0;
    bit               m_acked = 1'b0;
    int               m_b     = 0;
    int               m_done  = 0;
    logic [ADR_W-1:0] m_adr   = '0;
    logic [31:0]      m_dat   = 32'h0;
    logic [3:0]       m_sel   = 4'h0;
    logic             m_we    = 1'b0;
    logic [31:0]      m_rdt   = 32'h0;
    logic             m_err   = 1'b0;

    task automatic check_output(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("[TB] FAIL %s at cycle %0d: got 0x%0h, expected 0x%0h", name, cyc_n, got, exp);
        end
    endtask

    task automatic fail_bound(input string name);
        checks++;
        failures++;
        $display("[TB] FAIL %s at cycle %0d: wait bound expired", name, cyc_n);
    endtask

    // A command accepted with plan_ack=a completes after a cyc cycles if 1<=a<=TMO, else after TMO.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_busy <= 1'b0;
            m_adr  <= '0;
            m_dat  <= 32'h0;
            m_sel  <= 4'h0;
            m_we   <= 1'b0;
            m_rdt  <= 32'h0;
            m_err  <= 1'b0;
        end else begin
            cyc_n <= cyc_n + 1;
            if (!m_busy) begin
                if (bus.i_cmd_valid) begin
                    m_busy  <= 1'b1;
                    m_b     <= cyc_n + 1;
                    m_acked <= (plan_ack >= 1) && (plan_ack <= TMO);
                    m_done  <= ((plan_ack >= 1) && (plan_ack <= TMO)) ? plan_ack : TMO;
                    m_adr   <= bus.i_cmd_adr;
                    m_dat   <= bus.i_cmd_dat;
                    m_sel   <= bus.i_cmd_sel;
                    m_we    <= bus.i_cmd_we;
                end
            end else if (cyc_n == m_b + m_done - 1) begin
                m_rdt <= (m_acked && !m_we) ? bus.i_wb_rdt : 32'h0;
                m_err <= !m_acked;
            end else if ((cyc_n >= m_b + m_done) && bus.i_rsp_ready) begin
                m_busy <= 1'b0;
            end
        end
    end

    initial begin : compare_proc
        logic exp_cyc;
        logic exp_valid;
        forever begin
            @(negedge clk);
            if (chk_en) begin
                exp_cyc   = m_busy && (cyc_n >= m_b) && (cyc_n < m_b + m_done);
                exp_valid = m_busy && (cyc_n >= m_b + m_done);
                check_output("cmd_ready", 32'(bus.o_cmd_ready), 32'(!m_busy));
                check_output("wb_cyc",    32'(bus.o_wb_cyc),    32'(exp_cyc));
                check_output("wb_stb",    32'(bus.o_wb_stb),    32'(exp_cyc));
                check_output("rsp_valid", 32'(bus.o_rsp_valid), 32'(exp_valid));
                check_output("wb_adr",    32'(bus.o_wb_adr),    32'(m_adr));
                check_output("wb_dat",    bus.o_wb_dat,         m_dat);
                check_output("wb_sel",    32'(bus.o_wb_sel),    32'(m_sel));
                check_output("wb_we",     32'(bus.o_wb_we),     32'(m_we));
                if (exp_valid || !rst_n) begin
                    check_output("rsp_rdt", bus.o_rsp_rdt,      m_rdt);
                    check_output("rsp_err", 32'(bus.o_rsp_err), 32'(m_err));
                end
            end
        end
    end

    // Slave: acks during the plan_ack-th cycle of cyc, random ack noise while cyc is low.
    initial begin : slave_proc
        int s_cnt;
        s_cnt        = 0;
        bus.i_wb_ack = 1'b0;
        bus.i_wb_rdt = 32'h0;
        forever begin
            @(negedge clk);
            if (bus.o_wb_cyc === 1'b1) begin
                s_cnt++;
                bus.i_wb_ack = (s_cnt == plan_ack);
            end else begin
                s_cnt        = 0;
                bus.i_wb_ack = spurious_en && ($urandom_range(0, 1) == 1);
            end
            bus.i_wb_rdt = rdt_fix_en ? rdt_fix : $urandom;
        end
    end

    task automatic scramble_cmd();
        bus.i_cmd_adr = ADR_W'($urandom);
        bus.i_cmd_dat = $urandom;
        bus.i_cmd_sel = 4'($urandom);
        bus.i_cmd_we  = 1'($urandom);
    endtask

    task automatic apply_stimulus(input logic [ADR_W-1:0] adr, input logic [31:0] dat,
                                  input logic [3:0] sel, input logic we,
                                  input int ack_at, input int hold,
                                  output int n_cyc, output int lat,
                                  output logic [31:0] rdt, output logic err);
        int guard;
        n_cyc    = 0;
        lat      = 0;
        rdt      = 32'h0;
        err      = 1'b0;
        plan_ack = ack_at;
        bus.i_cmd_adr   = adr;
        bus.i_cmd_dat   = dat;
        bus.i_cmd_sel   = sel;
        bus.i_cmd_we    = we;
        bus.i_cmd_valid = 1'b1;
        bus.i_rsp_ready = 1'b0;
        guard = 0;
        while (bus.o_cmd_ready !== 1'b1 && guard < 20) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 20) begin
            fail_bound("accept_wait");
            bus.i_cmd_valid = 1'b0;
            return;
        end
        @(negedge clk);
        lat = 1;
        bus.i_cmd_valid = 1'b0;
        scramble_cmd();
        while (bus.o_rsp_valid !== 1'b1 && lat < 40) begin
            if (bus.o_wb_cyc === 1'b1) n_cyc++;
            bus.i_rsp_ready = 1'($urandom);
            @(negedge clk);
            lat++;
        end
        bus.i_rsp_ready = 1'b0;
        if (bus.o_rsp_valid !== 1'b1) begin
            fail_bound("rsp_wait");
            return;
        end
        for (int i = 0; i < hold; i++) begin
            check_output("bp_cmd_ready", 32'(bus.o_cmd_ready), 32'h0);
            check_output("bp_cyc",       32'(bus.o_wb_cyc),    32'h0);
            @(negedge clk);
        end
        rdt = bus.o_rsp_rdt;
        err = bus.o_rsp_err;
        bus.i_rsp_ready = 1'b1;
        @(negedge clk);
        bus.i_rsp_ready = 1'b0;
        check_output("idle_after_release", 32'(bus.o_cmd_ready), 32'h1);
    endtask

    initial begin : main_proc
        int          n_cyc;
        int          lat;
        logic [31:0] rdt;
        logic        err;
        int          ack;

        bus.i_cmd_valid = 1'b0;
        bus.i_rsp_ready = 1'b0;
        bus.i_cmd_adr   = '0;
        bus.i_cmd_dat   = 32'h0;
        bus.i_cmd_sel   = 4'h0;
        bus.i_cmd_we    = 1'b0;

        #1 rst_n = 1'b0;
        @(negedge clk);
        chk_en = 1'b1;
        @(negedge clk);
        check_output("reset_cmd_ready", 32'(bus.o_cmd_ready), 32'h1);
        check_output("reset_cyc",       32'(bus.o_wb_cyc),    32'h0);
        check_output("reset_rsp_valid", 32'(bus.o_rsp_valid), 32'h0);
        rst_n = 1'b1;
        @(negedge clk);

        // Syscon-style write: ack in the second cyc cycle.
        apply_stimulus(6'h38, 32'h0000_1234, 4'hF, 1'b1, 2, 0, n_cyc, lat, rdt, err);
        check_output("write_cyc_len", 32'(n_cyc), 32'd2);
        check_output("write_latency", 32'(lat),   32'd3);
        check_output("write_rdt",     rdt,        32'h0);
        check_output("write_err",     32'(err),   32'h0);

        rdt_fix_en = 1'b1;
        rdt_fix    = 32'h05F5_E100;
        apply_stimulus(6'h3C, 32'hDEAD_BEEF, 4'hF, 1'b0, 2, 0, n_cyc, lat, rdt, err);
        check_output("read_rdt",     rdt,      32'h05F5_E100);
        check_output("read_err",     32'(err), 32'h0);
        check_output("read_latency", 32'(lat), 32'd3);

        rdt_fix = 32'hCAFE_F00D;
        apply_stimulus(6'h10, 32'h0, 4'hF, 1'b0, 0, 0, n_cyc, lat, rdt, err);
        check_output("timeout_cyc_len", 32'(n_cyc), 32'd8);
        check_output("timeout_err",     32'(err),   32'h1);
        check_output("timeout_rdt",     rdt,        32'h0);

        apply_stimulus(6'h14, 32'h0, 4'h3, 1'b0, TMO, 0, n_cyc, lat, rdt, err);
        check_output("coincide_err",     32'(err),   32'h0);
        check_output("coincide_rdt",     rdt,        32'hCAFE_F00D);
        check_output("coincide_cyc_len", 32'(n_cyc), 32'd8);
        rdt_fix_en = 1'b0;

        apply_stimulus(6'h20, 32'h1111_2222, 4'h5, 1'b1, 3, 10, n_cyc, lat, rdt, err);
        check_output("bp_err", 32'(err), 32'h0);

        // Reset in the middle of a bus cycle that would otherwise time out.
        plan_ack        = 0;
        bus.i_cmd_adr   = 6'h2A;
        bus.i_cmd_dat   = 32'h5A5A_A5A5;
        bus.i_cmd_sel   = 4'hC;
        bus.i_cmd_we    = 1'b1;
        bus.i_cmd_valid = 1'b1;
        @(negedge clk);
        bus.i_cmd_valid = 1'b0;
        repeat (3) @(negedge clk);
        check_output("rst_pre_cyc", 32'(bus.o_wb_cyc), 32'h1);
        #2 rst_n = 1'b0;
        #1;
        check_output("rst_async_cyc", 32'(bus.o_wb_cyc), 32'h0);
        check_output("rst_async_stb", 32'(bus.o_wb_stb), 32'h0);
        check_output("rst_async_adr", 32'(bus.o_wb_adr), 32'h0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (6) begin
            @(negedge clk);
            check_output("rst_no_rsp", 32'(bus.o_rsp_valid), 32'h0);
        end

        for (int t = 0; t < 80; t++) begin
            repeat ($urandom_range(0, 2)) begin
                scramble_cmd();
                @(negedge clk);
            end
            case ($urandom_range(0, 9))
                0:       ack = 0;
                1:       ack = TMO;
                2:       ack = TMO + 1 + int'($urandom_range(0, 3));
                default: ack = int'($urandom_range(1, TMO - 1));
            endcase
            apply_stimulus(ADR_W'($urandom), $urandom, 4'($urandom), 1'($urandom),
                           ack, int'($urandom_range(0, 3)), n_cyc, lat, rdt, err);
        end

        repeat (2) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin : watchdog
        #200000;
        failures++;
        $display("[TB] FAIL watchdog: simulation did not complete in time");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
